branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Tagged, direct-mapped branch target buffer with per-entry saturating direction counters.
//  It is the next generation of the untagged valid+target BTB in the processor pipeline.
//  Looked up with the IF-stage word PC; the prediction is returned registered in IG.
//  Updated from WA with the resolved branch outcome.
//  Adds partial tags, hysteresis counters, invalidation on aliasing, and a reset sweep.
// PARAMETERS
//  PC_W     30  word-PC width (byte PC >> 2)
//  IDX_W    10  index bits; 2**IDX_W entries
//  TAG_W     8  tag bits taken from pc[IDX_W +: TAG_W]; IDX_W+TAG_W <= PC_W required
//  CTR_W     2  direction counter width (>=1)
//  CTR_INIT  2  counter value written on allocation (weakly taken for CTR_W=2)
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  lookup_pc      in   PC_W   IF-stage word PC
//  pred_hit       out  1      IG: valid entry with matching tag for the previous lookup_pc
//  pred_taken     out  1      IG: pred_hit && counter MSB==1 && ready
//  pred_target    out  PC_W   IG: stored target; 0 unless pred_taken
//  upd_en         in   1      WA: resolved instruction is valid (not squashed)
//  upd_pc         in   PC_W   WA: PC of the resolved instruction
//  upd_is_branch  in   1      WA: instruction is j/beq/bne
//  upd_taken      in   1      WA: actual direction
//  upd_target     in   PC_W   WA: actual taken target
//  ready          out  1      0 during the init sweep; 1 otherwise
// BEHAVIOUR
//  - Reset: all outputs are 0 in the cycle after rst is asserted.
//    - The block enters INIT with sweep index 0.
//  - INIT: one entry per cycle gets valid=0, tag=0, target=0, ctr=0.
//    - The sweep index wraps after 2**IDX_W-1; the block then enters RUN with ready=1.
//    - INIT lasts exactly 2**IDX_W cycles after rst deasserts.
//    - rst during INIT restarts the sweep at index 0.
//    - In INIT, upd_en is ignored and pred_* are forced to 0.
//  - RUN lookup: 1-cycle latency.
//    - Index = lookup_pc[0+:IDX_W], tag = lookup_pc[IDX_W+:TAG_W].
//    - The entry is read at the clock edge; outputs are registered for IG.
//    - pred_taken = valid && tag match && ctr[CTR_W-1]. A weakly-not-taken hit predicts pc+1.
//  - RUN update: applied at the clock edge when upd_en=1. Cases:
//    - branch, hit: ctr saturating +1 if taken, -1 if not (bounds 0 and 2**CTR_W-1).
//      If taken, target <= upd_target. If not taken, target is unchanged.
//    - branch, miss, taken: allocate (overwrite the slot); valid=1, tag, target, ctr=CTR_INIT.
//    - branch, miss, not taken: no write.
//    - non-branch, hit: valid <= 0 (alias scrub).
//    - non-branch, miss: no write.
//  - Simultaneous lookup and update to the same index: read-first.
//    - The lookup returns the pre-update entry; there is no bypass.
//    - The following lookup sees the update.
//  - Only one write port exists. During INIT the sweep owns the write port.
//  - The pipeline owns the miss check (compare pred vs actual in MM).
//    - This block never signals misprediction itself.
// STRUCTURE
//  - Shared header BP.v holds:
//    - entry field layout: valid | tag | ctr | target, width 1+TAG_W+CTR_W+PC_W
//    - the CTR_W-derived constants CTR_MAX and CTR_MSB
//  - Sub-module btb_ram: 2**IDX_W x entry width, 1 sync read port, 1 sync write port, read-first.
//  - Top level contains:
//    - INIT/RUN FSM and the sweep counter
//    - hit/tag compare
//    - a combinational read-modify-write path for updates
//  - The update path re-reads the entry through a second read port or holds a shadow copy.
//    Implementation choice: btb_ram provides 2R1W.
// TESTING
//  - Reset sweep, IDX_W=4: pulse rst -> ready=0 for 16 cycles, then 1.
//    - Lookups of any PC give pred_hit=0.
//    - rst at sweep cycle 7 -> 16 more cycles to ready.
//  - Allocate: update pc=0x040, taken, target=0x100.
//    - Lookup 0x040 next cycle -> hit=1, taken=1 (ctr=2), target=0x100.
//  - Hysteresis: starting from ctr=2, apply not-taken x1 -> hit=1, taken=0.
//    - Apply taken x3 -> ctr=3 and it stays at 3.
//    - Apply not-taken x4 -> ctr=0 and it stays at 0.
//  - Tag alias: entry for 0x040; lookup 0x440 (same index, different tag) -> hit=0.
//    - Non-branch update at 0x040 -> subsequent lookup of 0x040 gives hit=0.
//  - Collision: lookup 0x040 and allocate-update 0x040 in the same cycle.
//    - That cycle's result is hit=0; the next lookup gives hit=1.
//  - Not-taken miss: update pc=0x080, not taken -> lookup 0x080 gives hit=0 (no allocation).

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the tagged branch target predictor.
// Entry layout (MSB..LSB): valid | tag | ctr | target.
package branch_target_predictor_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } btp_state_e;

  // Largest value a counter of the given width can hold.
  function automatic logic [31:0] ctr_max(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // One saturating step of a direction counter, clamped to [0, max].
  function automatic logic [31:0] ctr_step(input logic [31:0] ctr, input logic up,
                                           input logic [31:0] max);
    logic [31:0] nxt;
    if (up) begin
      nxt = (ctr >= max) ? max : ctr + 32'd1;
    end else begin
      nxt = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_predictor_ram.sv
// Entry storage: one synchronous read-first lookup port, one asynchronous
// port feeding the update read-modify-write path, and a single write port.
module branch_target_predictor_ram
  import branch_target_predictor_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 41
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] rmw_addr,
  output logic [DATA_W-1:0] rmw_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write and registered read share the edge, so a colliding read returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data <= mem_r[rd_addr];
  end

  assign rmw_data = mem_r[rmw_addr];

endmodule

// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped BTB with saturating direction counters, an init
// sweep after reset, and alias scrubbing on non-branch hits.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int PC_W     = 30,
  parameter int IDX_W    = 10,
  parameter int TAG_W    = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            ready
);

  localparam int          ENT_W   = 1 + TAG_W + CTR_W + PC_W;
  localparam int          NUM_ENT = 1 << IDX_W;
  localparam logic [31:0] CTR_MAX = ctr_max(CTR_W);
  localparam int          CTR_MSB = CTR_W - 1;
  localparam int          TGT_LSB = 0;
  localparam int          CTR_LSB = PC_W;
  localparam int          TAG_LSB = PC_W + CTR_W;
  localparam int          VLD_BIT = PC_W + CTR_W + TAG_W;

  btp_state_e         state_r;
  logic [IDX_W-1:0]   sweep_idx_r;
  logic               ready_r;
  logic               lk_valid_r;
  logic [TAG_W-1:0]   lk_tag_r;

  logic [ENT_W-1:0]   rd_data_s;
  logic [ENT_W-1:0]   rmw_data_s;
  logic               wr_en_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [ENT_W-1:0]   wr_data_s;
  logic               upd_hit_s;
  logic [CTR_W-1:0]   ctr_new_s;
  logic               unused_s;

  assign unused_s = ^{lookup_pc, upd_pc};

  branch_target_predictor_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (ENT_W)
  ) u_ram (
    .clk      (clk),
    .rd_addr  (lookup_pc[IDX_W-1:0]),
    .rd_data  (rd_data_s),
    .rmw_addr (upd_pc[IDX_W-1:0]),
    .rmw_data (rmw_data_s),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_idx_s),
    .wr_data  (wr_data_s)
  );

  // INIT/RUN sequencing, sweep counter, and lookup context held for the IG stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      sweep_idx_r <= {IDX_W{1'b0}};
      ready_r     <= 1'b0;
      lk_valid_r  <= 1'b0;
      lk_tag_r    <= {TAG_W{1'b0}};
    end else begin
      lk_valid_r <= (state_r == ST_RUN);
      lk_tag_r   <= lookup_pc[IDX_W +: TAG_W];
      case (state_r)
        ST_INIT: begin
          sweep_idx_r <= sweep_idx_r + 1'b1;
          if (sweep_idx_r == IDX_W'(NUM_ENT - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          sweep_idx_r <= {IDX_W{1'b0}};
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  // Tag compare on the registered entry; nothing is predicted until the sweep is done.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = {PC_W{1'b0}};
    if (lk_valid_r && rd_data_s[VLD_BIT] && (rd_data_s[TAG_LSB +: TAG_W] == lk_tag_r)) begin
      pred_hit = 1'b1;
      if (rd_data_s[CTR_LSB + CTR_MSB] && ready_r) begin
        pred_taken  = 1'b1;
        pred_target = rd_data_s[TGT_LSB +: PC_W];
      end else begin
        pred_taken  = 1'b0;
        pred_target = {PC_W{1'b0}};
      end
    end else begin
      pred_hit = 1'b0;
    end
  end

  assign upd_hit_s = rmw_data_s[VLD_BIT] &&
                     (rmw_data_s[TAG_LSB +: TAG_W] == upd_pc[IDX_W +: TAG_W]);
  assign ctr_new_s = CTR_W'(ctr_step(32'(rmw_data_s[CTR_LSB +: CTR_W]), upd_taken, CTR_MAX));

  // Single write port: the sweep owns it during INIT, resolved updates afterwards.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = upd_pc[IDX_W-1:0];
    wr_data_s = rmw_data_s;
    if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = sweep_idx_r;
      wr_data_s = {ENT_W{1'b0}};
    end else if (upd_en && !rst) begin
      if (upd_is_branch) begin
        if (upd_hit_s) begin
          wr_en_s                        = 1'b1;
          wr_data_s[CTR_LSB +: CTR_W]    = ctr_new_s;
          if (upd_taken) begin
            wr_data_s[TGT_LSB +: PC_W] = upd_target;
          end else begin
            wr_data_s[TGT_LSB +: PC_W] = rmw_data_s[TGT_LSB +: PC_W];
          end
        end else if (upd_taken) begin
          wr_en_s   = 1'b1;
          wr_data_s = {1'b1, upd_pc[IDX_W +: TAG_W], CTR_W'(CTR_INIT), upd_target};
        end else begin
          wr_en_s = 1'b0;
        end
      end else if (upd_hit_s) begin
        wr_en_s            = 1'b1;
        wr_data_s[VLD_BIT] = 1'b0;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  assign ready = ready_r;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor (IDX_W=4): a driver pushes
// expectations from an array-based reference model, a monitor pops and compares.
module tb_branch_target_predictor;

  localparam int PC_W     = 30;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = 8;
  localparam int CTR_W    = 2;
  localparam int CTR_INIT = 2;
  localparam int N        = 1 << IDX_W;
  localparam int CMAX     = (1 << CTR_W) - 1;
  localparam int THR      = 1 << (CTR_W - 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PC_W-1:0] lookup_pc = '0;
  logic            pred_hit, pred_taken, ready;
  logic [PC_W-1:0] pred_target;
  logic            upd_en = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0;
  logic [PC_W-1:0] upd_pc = '0, upd_target = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit              hit;
    bit              taken;
    logic [PC_W-1:0] tgt;
  } exp_t;
  exp_t sb[$];

  bit              m_valid[N];
  int              m_tag[N];
  int              m_ctr[N];
  logic [PC_W-1:0] m_tgt[N];

  branch_target_predictor #(
    .PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W), .CTR_INIT(CTR_INIT)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'(pc % N);
  endfunction

  function automatic int tag_of(input logic [PC_W-1:0] pc);
    return int'((pc / N) % (1 << TAG_W));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_ctr[i] = 0; m_tgt[i] = '0;
    end
  endtask

  // One cycle of stimulus; the expectation uses the model before this cycle's update.
  task automatic drive(input logic [PC_W-1:0] lpc, input bit ue, input logic [PC_W-1:0] upc,
                       input bit br, input bit tk, input logic [PC_W-1:0] tgt);
    exp_t e;
    int li, ui;
    bit uhit;
    @(negedge clk);
    lookup_pc = lpc; upd_en = ue; upd_pc = upc;
    upd_is_branch = br; upd_taken = tk; upd_target = tgt;
    li = idx_of(lpc);
    e.hit   = m_valid[li] && (m_tag[li] == tag_of(lpc));
    e.taken = e.hit && (m_ctr[li] >= THR);
    e.tgt   = e.taken ? m_tgt[li] : '0;
    sb.push_back(e);
    if (ue) begin
      ui   = idx_of(upc);
      uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
      if (br && uhit) begin
        m_ctr[ui] = tk ? ((m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX)
                       : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
        if (tk) m_tgt[ui] = tgt;
      end else if (br && tk) begin
        m_valid[ui] = 1'b1; m_tag[ui] = tag_of(upc); m_ctr[ui] = CTR_INIT; m_tgt[ui] = tgt;
      end else if (!br && uhit) begin
        m_valid[ui] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Counts negedges until ready rises, with ignored updates and random lookups meanwhile.
  task automatic measure_sweep(output int n);
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
      chk("sweep_hit", pred_hit, 1'b0);
      chk("sweep_taken", pred_taken, 1'b0);
      lookup_pc = PC_W'($urandom);
      upd_en = 1'b1; upd_is_branch = 1'b1; upd_taken = 1'b1;
      upd_pc = PC_W'($urandom); upd_target = PC_W'($urandom);
    end
    upd_en = 1'b0;
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    logic [PC_W-1:0] p;
    p = PC_W'($urandom_range(0, 3) * N + $urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) p[PC_W-1:IDX_W+TAG_W] = (PC_W-IDX_W-TAG_W)'($urandom);
    return p;
  endfunction

  // Monitor: every prediction cycle presents one response, paired in order with the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pred_hit", pred_hit, e.hit);
        chk("pred_taken", pred_taken, e.taken);
        chk("pred_target", pred_target, e.tgt);
        chk("ready", ready, 1'b1);
      end
    end
  end

  initial begin
    int n;
    logic [PC_W-1:0] a, b, c;
    a = 30'h040; b = 30'h440; c = 30'h080;
    model_clear();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_hit", pred_hit, 1'b0);
    chk("rst_taken", pred_taken, 1'b0);
    chk("rst_target", pred_target, '0);
    measure_sweep(n);
    chk("sweep_len", n, 16);

    // Restart the sweep partway through.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_sweep_ready", ready, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("restart_ready", ready, 1'b0);
    measure_sweep(n);
    chk("restart_len", n, 16);

    drive('0, 1'b1, a, 1'b1, 1'b1, 30'h100);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(a, 1'b1, a, 1'b1, 1'b0, '0);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (3) drive(a, 1'b1, a, 1'b1, 1'b1, 30'h104);
    drive(a, 1'b1, a, 1'b1, 1'b0, '0);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (4) drive(a, 1'b1, a, 1'b1, 1'b0, '0);
    drive(a, 1'b1, a, 1'b1, 1'b0, '0);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(b, 1'b0, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b1, b, 1'b0, 1'b0, '0);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b1, a, 1'b0, 1'b0, '0);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(a, 1'b1, a, 1'b1, 1'b1, 30'h200);
    drive(a, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(c, 1'b1, c, 1'b1, 1'b0, '0);
    drive(c, 1'b0, '0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 600; i++) begin
      drive(rand_pc(), ($urandom_range(0, 3) != 0), rand_pc(),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0), PC_W'($urandom));
    end
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
